decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 33 +++
 rtl/decode_stage.sv | 176 +++++++++++++++++
 tb/tb_decode_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/execute handshake bundle for decode_stage
interface decode_stage_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_insn;
  logic [PC_W-1:0]   in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [9:0]        out_ctrl;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_dst;
  logic [DATA_W-1:0] out_imm;
  logic [PC_W-1:0]   out_pc;
  logic              out_illegal;
  logic              out_nop;

  modport master (
    output in_valid, in_insn, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_rs, out_rt, out_dst,
           out_imm, out_pc, out_illegal, out_nop
  );

  modport slave (
    input  in_valid, in_insn, in_pc, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_rs, out_rt, out_dst,
           out_imm, out_pc, out_illegal, out_nop
  );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS-subset decoder feeding a 2-entry in-order buffer
// Define DECODE_MULDIV_EN to add DIV/DIVU/MFHI/MFLO/MUL decode.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);

  localparam logic [9:0] C_BR     = 10'b10_0000_0000;
  localparam logic [9:0] C_JP     = 10'b01_0000_0000;
  localparam logic [9:0] C_JR     = 10'b00_1000_0000;
  localparam logic [9:0] C_ALUINB = 10'b00_0100_0000;
  localparam logic [9:0] C_ALUOP  = 10'b00_0010_0000;
  localparam logic [9:0] C_DMWE   = 10'b00_0001_0000;
  localparam logic [9:0] C_RWE    = 10'b00_0000_1000;
  localparam logic [9:0] C_RDST   = 10'b00_0000_0100;
  localparam logic [9:0] C_RWD    = 10'b00_0000_0010;
  localparam logic [9:0] C_RA     = 10'b00_0000_0001;

  typedef struct packed {
    logic [9:0]        ctrl;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dst;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pc;
    logic              illegal;
    logic              nop;
  } entry_t;

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        rs_f;
  logic [4:0]        rt_f;
  logic [4:0]        rd_f;
  logic [15:0]       imm16;
  logic [25:0]       index26;
  logic [PC_W-1:0]   jtarget;
  logic [9:0]        ctrl;
  logic              legal;
  logic              is_nop;
  logic [DATA_W-1:0] imm;
  entry_t            dec;

  assign opcode  = bus.in_insn[31:26];
  assign rs_f    = bus.in_insn[25:21];
  assign rt_f    = bus.in_insn[20:16];
  assign rd_f    = bus.in_insn[15:11];
  assign funct   = bus.in_insn[5:0];
  assign imm16   = bus.in_insn[15:0];
  assign index26 = bus.in_insn[25:0];
  assign is_nop  = (bus.in_insn == 32'h0);
  assign jtarget = {bus.in_pc[PC_W-1:28], index26, 2'b00};

  always_comb begin
    ctrl  = '0;
    legal = 1'b1;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07:
            ctrl = C_RWE | C_RDST;
          6'h08: ctrl = C_JP | C_JR;
          6'h09: ctrl = C_JP | C_JR | C_RWE | C_RDST;
`ifdef DECODE_MULDIV_EN
          6'h10, 6'h12: ctrl = C_RWE | C_RDST;
          // DIV/DIVU only write HI/LO, so no GPR control is raised
          6'h1A, 6'h1B: ctrl = '0;
`endif
          default: legal = 1'b0;
        endcase
      end
      6'h01: begin
        if (rt_f[4:1] == 4'd0) ctrl = C_BR | C_ALUOP;
        else                   legal = 1'b0;
      end
      6'h02: ctrl = C_JP;
      6'h03: ctrl = C_JP | C_RA | C_RWE;
      6'h04, 6'h05, 6'h06, 6'h07: ctrl = C_BR | C_ALUOP;
      6'h09, 6'h0A, 6'h0B, 6'h0D, 6'h0E, 6'h0F: ctrl = C_ALUINB | C_RWE;
      6'h20, 6'h23, 6'h24: ctrl = C_ALUINB | C_RWE | C_RWD;
      6'h28, 6'h2B: ctrl = C_ALUINB | C_DMWE;
`ifdef DECODE_MULDIV_EN
      6'h1C: begin
        if (funct == 6'h02) ctrl = C_RWE | C_RDST;
        else                legal = 1'b0;
      end
`endif
      default: legal = 1'b0;
    endcase
    // all-zero word is SLL $0,$0,0 but is reported as a bubble instead
    if (is_nop) begin
      ctrl  = '0;
      legal = 1'b1;
    end
    if (!legal) ctrl = '0;
  end

  always_comb begin
    imm = '0;
    case (opcode)
      6'h0D, 6'h0E: imm = DATA_W'(imm16);
      6'h0F:        imm = DATA_W'($signed({imm16, 16'h0000}));
      6'h02, 6'h03: imm = DATA_W'(jtarget);
      default:      imm = DATA_W'($signed(imm16));
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.ctrl    = ctrl;
    dec.rs      = rs_f;
    dec.rt      = rt_f;
    dec.dst     = ctrl[0] ? 5'd31 : (ctrl[2] ? rd_f : rt_f);
    dec.imm     = imm;
    dec.pc      = bus.in_pc;
    dec.illegal = ~legal;
    dec.nop     = is_nop;
  end

  entry_t     mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       ready_en;
  logic       accept;
  logic       drain;
  entry_t     head;

  // ready_en keeps in_ready low through reset and rises on the first clean edge
  assign bus.in_ready  = ready_en && (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign accept        = bus.in_valid && bus.in_ready;
  assign drain         = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (bus.flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (accept) begin
          mem[wr_ptr] <= dec;
          wr_ptr      <= ~wr_ptr;
        end
        if (drain) rd_ptr <= ~rd_ptr;
        if (accept && !drain)      count <= count + 2'd1;
        else if (drain && !accept) count <= count - 2'd1;
      end
    end
  end

  assign head            = mem[rd_ptr];
  assign bus.out_ctrl    = head.ctrl;
  assign bus.out_rs      = head.rs;
  assign bus.out_rt      = head.rt;
  assign bus.out_dst     = head.dst;
  assign bus.out_imm     = head.imm;
  assign bus.out_pc      = head.pc;
  assign bus.out_illegal = head.illegal;
  assign bus.out_nop     = head.nop;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and random checks of decode_stage against a table-driven model
module tb_decode_stage;
  localparam int DATA_W = 64;
  localparam int PC_W   = 32;

  localparam int BR = 512, JP = 256, JR = 128, ALUINB = 64, ALUOP = 32;
  localparam int DMWE = 16, RWE = 8, RDST = 4, RWD = 2, RA = 1;

  typedef struct {
    logic [9:0]  ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [63:0] imm;
    logic [31:0] pc;
    logic        ill;
    logic        nop;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();
  decode_stage #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t q[$];
  bit   rdy_en;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   rtab[int];
  int   itab[int];
  bit   muldiv;
  int   alu_f[16] = '{32, 33, 34, 35, 42, 43, 0, 4, 2, 6, 3, 7, 36, 37, 38, 39};
  int   pool_op[20] = '{2, 3, 4, 5, 6, 7, 9, 10, 11, 13, 14, 15, 32, 35, 36, 40, 43, 28, 63, 17};
  int   pool_fn[24] = '{32, 33, 34, 35, 42, 43, 0, 4, 2, 6, 3, 7, 36, 37, 38, 39,
                        8, 9, 16, 18, 26, 27, 1, 63};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] insn, input logic [31:0] pc);
    exp_t   e;
    int     op, fn, rt;
    bit     legal;
    longint uv, sv, imm;
    op = int'(insn[31:26]);
    fn = int'(insn[5:0]);
    rt = int'(insn[20:16]);
    e.rs = insn[25:21];
    e.rt = insn[20:16];
    e.pc = pc;
    e.nop = 1'b0;
    e.ctrl = '0;
    legal = 1'b0;
    if (insn == 32'h0) begin
      e.nop = 1'b1;
      legal = 1'b1;
    end else if (op == 0) begin
      if (rtab.exists(fn)) begin legal = 1'b1; e.ctrl = 10'(rtab[fn]); end
    end else if (op == 1) begin
      if (rt <= 1) begin legal = 1'b1; e.ctrl = 10'(BR + ALUOP); end
    end else if (op == 28) begin
      if (muldiv && fn == 2) begin legal = 1'b1; e.ctrl = 10'(RWE + RDST); end
    end else if (itab.exists(op)) begin
      legal = 1'b1;
      e.ctrl = 10'(itab[op]);
    end
    e.ill = !legal;
    if ((int'(e.ctrl) & RA) != 0)        e.dst = 5'd31;
    else if ((int'(e.ctrl) & RDST) != 0) e.dst = insn[15:11];
    else                                 e.dst = insn[20:16];
    uv = longint'(insn[15:0]);
    sv = (uv >= 32768) ? uv - 65536 : uv;
    case (op)
      13, 14:  imm = uv;
      15:      imm = sv * 65536;
      2, 3:    imm = longint'(pc & 32'hF000_0000) + longint'(insn[25:0]) * 4;
      default: imm = sv;
    endcase
    e.imm = imm;
    return e;
  endfunction

  task automatic compare();
    check("in_ready", bus.in_ready, rdy_en && (q.size() < 2));
    check("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("ctrl", bus.out_ctrl, q[0].ctrl);
      check("rs", bus.out_rs, q[0].rs);
      check("rt", bus.out_rt, q[0].rt);
      check("dst", bus.out_dst, q[0].dst);
      check("imm", bus.out_imm, q[0].imm);
      check("pc", bus.out_pc, q[0].pc);
      check("illegal", bus.out_illegal, q[0].ill);
      check("nop", bus.out_nop, q[0].nop);
    end
  endtask

  task automatic tick(input bit v, input logic [31:0] insn, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    bit acc, drn;
    bus.in_valid  = v;
    bus.in_insn   = insn;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    acc = v && rdy_en && (q.size() < 2);
    drn = (q.size() > 0) && ordy;
    @(posedge clk);
    rdy_en = 1'b1;
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(model(insn, pc));
    end
    @(negedge clk);
    compare();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    q.delete();
    rdy_en = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_ctrl", bus.out_ctrl, 0);
    check("rst_imm", bus.out_imm, 0);
    check("rst_pc", bus.out_pc, 0);
    check("rst_dst", bus.out_dst, 0);
    check("rst_flags", {bus.out_illegal, bus.out_nop}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", bus.in_ready, 0);
  endtask

  initial begin
    logic [31:0] r, insn;
    int sel;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_insn = '0;
    bus.in_pc = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
`ifdef DECODE_MULDIV_EN
    muldiv = 1'b1;
`else
    muldiv = 1'b0;
`endif
    foreach (alu_f[i]) rtab[alu_f[i]] = RWE + RDST;
    rtab[8] = JP + JR;
    rtab[9] = JP + JR + RWE + RDST;
    if (muldiv) begin
      rtab[16] = RWE + RDST;
      rtab[18] = RWE + RDST;
      rtab[26] = 0;
      rtab[27] = 0;
    end
    itab[2] = JP;
    itab[3] = JP + RA + RWE;
    for (int o = 4; o <= 7; o++) itab[o] = BR + ALUOP;
    foreach (pool_op[i]) if (pool_op[i] >= 9 && pool_op[i] <= 15 && pool_op[i] != 12)
      itab[pool_op[i]] = ALUINB + RWE;
    itab[32] = ALUINB + RWE + RWD;
    itab[35] = ALUINB + RWE + RWD;
    itab[36] = ALUINB + RWE + RWD;
    itab[40] = ALUINB + DMWE;
    itab[43] = ALUINB + DMWE;

    apply_reset();
    tick(0, 32'h0, 32'h0, 1, 0);
    check("ready_after_reset", bus.in_ready, 1);

    tick(1, 32'h0232_8020, 32'h0000_0100, 1, 0);
    check("add_valid", bus.out_valid, 1);
    check("add_ctrl", bus.out_ctrl, 10'h00C);
    check("add_dst", bus.out_dst, 16);
    tick(0, 32'h0, 32'h0, 1, 0);

    tick(1, 32'h0232_8020, 32'h0000_0200, 0, 0);
    tick(1, 32'h3408_1234, 32'h0000_0204, 0, 0);
    check("full_in_ready", bus.in_ready, 0);
    tick(1, 32'h8C08_0004, 32'h0000_0208, 0, 0);
    check("stall_head_pc", bus.out_pc, 32'h200);
    tick(1, 32'h8C08_0004, 32'h0000_0208, 1, 0);
    check("after_drain_ready", bus.in_ready, 1);
    check("second_head_pc", bus.out_pc, 32'h204);
    tick(1, 32'h8C08_0004, 32'h0000_0208, 1, 0);
    check("third_head_pc", bus.out_pc, 32'h208);
    tick(0, 32'h0, 32'h0, 1, 0);

    tick(1, 32'h2408_FFFF, 32'h0000_0300, 1, 0);
    check("addiu_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(1, 32'h3408_FFFF, 32'h0000_0304, 1, 0);
    check("ori_imm", bus.out_imm, 64'h0000_0000_0000_FFFF);
    tick(1, 32'h3C08_8000, 32'h0000_0308, 1, 0);
    check("lui_imm", bus.out_imm, 64'hFFFF_FFFF_8000_0000);
    tick(1, 32'h0C00_0010, 32'h4000_0000, 1, 0);
    check("jal_dst", bus.out_dst, 31);
    check("jal_imm", bus.out_imm, 64'h4000_0040);
    check("jal_ctrl", bus.out_ctrl, 10'h109);
    tick(1, 32'h0062_001A, 32'h0000_0400, 1, 0);
    check("div_illegal", bus.out_illegal, !muldiv);
    tick(1, 32'h7062_1002, 32'h0000_0404, 1, 0);
    check("mul_illegal", bus.out_illegal, !muldiv);
    tick(1, 32'hFC00_0000, 32'h0000_0408, 1, 0);
    check("op3f_illegal", bus.out_illegal, 1);
    check("op3f_ctrl", bus.out_ctrl, 0);
    tick(1, 32'h0000_0000, 32'h0000_040C, 1, 0);
    check("nop_flag", bus.out_nop, 1);
    check("nop_ctrl", bus.out_ctrl, 0);
    tick(0, 32'h0, 32'h0, 1, 0);

    tick(1, 32'h0232_8020, 32'h0000_0500, 0, 0);
    tick(1, 32'h0232_8020, 32'h0000_0504, 0, 0);
    tick(1, 32'h2408_0001, 32'h0000_0508, 1, 1);
    check("flush_valid", bus.out_valid, 0);
    tick(0, 32'h0, 32'h0, 1, 0);
    check("flush_no_emit", bus.out_valid, 0);

    tick(1, 32'h0232_8020, 32'h0000_0600, 0, 0);
    tick(1, 32'h0232_8020, 32'h0000_0604, 0, 0);
    apply_reset();
    tick(0, 32'h0, 32'h0, 1, 0);
    check("reset_lost_valid", bus.out_valid, 0);

    for (int n = 0; n < 800; n++) begin
      r = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:          insn = 32'h0;
        1, 2, 3:    insn = {6'd0, r[25:6], 6'(pool_fn[$urandom_range(0, 23)])};
        4, 5, 6, 7: insn = {6'(pool_op[$urandom_range(0, 19)]), r[25:0]};
        8:          insn = {6'd1, r[25:21], 5'($urandom_range(0, 3)), r[15:0]};
        default:    insn = r;
      endcase
      tick($urandom_range(0, 9) < 7, insn, $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
